// File: rtl/rate_meter.sv
// rate_meter: counts clock_50 cycles between slow_clk transitions (both polarities).
// Define RATE_METER_LOCK_EN to build lock detection; otherwise locked is tied low.
module rate_meter #(
    parameter int CNT_W   = 28,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic             clock_50,
    input  logic             reset,
    input  logic             en,
    input  logic             slow_clk,
    output logic [CNT_W-1:0] interval_out,
    output logic             valid,
    output logic             locked,
    output logic             stalled
);

    // state   | meaning
    // IDLE    | no reference edge yet since reset; counter held at 0
    // MEASURE | counting clock_50 cycles since the last slow_clk edge
    // STALL   | TIMEOUT reached without an edge; interval_out held
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALL   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic             r_edge;
    logic             w_edge;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_interval;
    logic             r_valid;
    logic             r_stalled;

    assign w_edge = r_s2 ^ r_s3;

    // r_edge retimes the detected transition so valid lands three cycles after s1 samples it.
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_s1   <= slow_clk;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_edge <= w_edge;
        end
    end

`ifdef RATE_METER_LOCK_EN
    logic r_locked;
`endif

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_interval <= '0;
            r_valid    <= 1'b0;
            r_stalled  <= 1'b0;
`ifdef RATE_METER_LOCK_EN
            r_locked   <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            if (en) begin
                case (r_state)
                    IDLE: begin
                        if (r_edge) begin
                            r_state <= MEASURE;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                    MEASURE: begin
                        // An edge coinciding with the timeout still reports the interval.
                        if (r_edge) begin
                            r_interval <= r_cnt;
                            r_valid    <= 1'b1;
                            r_cnt      <= CNT_ONE;
`ifdef RATE_METER_LOCK_EN
                            r_locked   <= (r_cnt == r_interval);
`endif
                        end else if (r_cnt >= TIMEOUT_C) begin
                            r_state   <= STALL;
                            r_stalled <= 1'b1;
`ifdef RATE_METER_LOCK_EN
                            r_locked  <= 1'b0;
`endif
                        end else if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    STALL: begin
                        if (r_edge) begin
                            r_state   <= MEASURE;
                            r_cnt     <= CNT_ONE;
                            r_stalled <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign interval_out = r_interval;
    assign valid        = r_valid;
    assign stalled      = r_stalled;
`ifdef RATE_METER_LOCK_EN
    assign locked       = r_locked;
`else
    assign locked       = 1'b0;
`endif

endmodule

// File: tb/tb_rate_meter.sv
// tb_rate_meter: directed and randomized stimulus for rate_meter against an
// interval-arithmetic reference model (counted cycles between consumed edges).
module tb_rate_meter;

    localparam int     CNT_W   = 12;
    localparam int     TIMEOUT = 20;
    localparam longint CMAX    = (64'd1 << CNT_W) - 1;

    logic             clock_50 = 1'b0;
    logic             reset    = 1'b1;
    logic             en       = 1'b0;
    logic             slow_clk = 1'b0;
    logic [CNT_W-1:0] interval_out;
    logic             valid;
    logic             locked;
    logic             stalled;

    rate_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clock_50     (clock_50),
        .reset        (reset),
        .en           (en),
        .slow_clk     (slow_clk),
        .interval_out (interval_out),
        .valid        (valid),
        .locked       (locked),
        .stalled      (stalled)
    );

    always #5 clock_50 = ~clock_50;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: slow_clk level seen at each posedge; a transition sampled
    // at edge k is acted on at edge k+3. Intervals are differences of en=1 edge counts.
    bit     h [4];
    bit     m_meas;
    longint m_cc;
    longint m_last;
    longint e_int;
    bit     e_valid;
    bit     e_lock;
    bit     e_stall;
    bit     prev_valid = 1'b0;
    bit     done       = 1'b0;

    task automatic model_step();
        bit     ev;
        longint iv;
        if (reset) begin
            for (int i = 0; i < 4; i++) h[i] = 1'b0;
            m_meas  = 1'b0;
            m_cc    = 0;
            m_last  = 0;
            e_int   = 0;
            e_valid = 1'b0;
            e_lock  = 1'b0;
            e_stall = 1'b0;
            return;
        end
        ev   = h[2] ^ h[3];
        h[3] = h[2];
        h[2] = h[1];
        h[1] = h[0];
        h[0] = slow_clk;
        e_valid = 1'b0;
        if (!en) return;
        m_cc++;
        if (ev) begin
            if (m_meas) begin
                iv = m_cc - m_last;
                if (iv > CMAX) iv = CMAX;
`ifdef RATE_METER_LOCK_EN
                e_lock = (iv == e_int);
`endif
                e_int   = iv;
                e_valid = 1'b1;
            end else begin
                m_meas  = 1'b1;
                e_stall = 1'b0;
            end
            m_last = m_cc;
        end else if (m_meas && (m_cc - m_last) >= TIMEOUT) begin
            m_meas  = 1'b0;
            e_stall = 1'b1;
            e_lock  = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clock_50);
            model_step();
            #1;
            if (!done) begin
                check("valid", valid, e_valid);
                check("interval", interval_out, e_int);
                check("stalled", stalled, e_stall);
                check("locked", locked, e_lock);
                check("valid_back_to_back", valid & prev_valid, 0);
                prev_valid = valid;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock_50);
    endtask

    task automatic toggles(input int period, input int count);
        for (int i = 0; i < count; i++) begin
            cyc(period);
            slow_clk = ~slow_clk;
        end
    endtask

    initial begin
        int cd;
        cyc(3);
        reset = 1'b0;
        en    = 1'b1;

        toggles(5, 12);
        cyc(4);
        check("intv_p5", interval_out, 5);

        toggles(7, 6);
        cyc(4);
        check("intv_p7", interval_out, 7);

        cyc(40);
        check("stall_set", stalled, 1);
        check("stall_hold_intv", interval_out, 7);
        toggles(5, 1);
        cyc(4);
        check("stall_clear", stalled, 0);
        toggles(5, 6);

        toggles(8, 4);
        cyc(4);
        en = 1'b0;
        cyc(10);
        en = 1'b1;
        cyc(4);
        slow_clk = ~slow_clk;
        cyc(6);
        check("en_freeze_intv", interval_out, 8);

        en = 1'b0;
        toggles(3, 2);
        cyc(5);
        en = 1'b1;
        toggles(8, 3);

        toggles(6, 3);
        cyc(3);
        reset = 1'b1;
        #1;
        check("rst_async_intv", interval_out, 0);
        check("rst_async_valid", valid, 0);
        check("rst_async_stalled", stalled, 0);
        check("rst_async_locked", locked, 0);
        cyc(3);
        reset = 1'b0;
        toggles(6, 4);

        cd = 3;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock_50);
            en = ($urandom_range(0, 7) != 0);
            if (cd == 0) begin
                slow_clk = ~slow_clk;
                cd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 45))
                                                 : int'($urandom_range(1, 12));
            end else begin
                cd--;
            end
        end

        en = 1'b1;
        cyc(5);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
